// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps ABCD through 0..15, waits SETTLE_CYC cycles per step, samples F and
// compares the captured truth table against EXP_MASK.
module truth_table_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [15:0] EXP_MASK   = 16'hAAF8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  abcd,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mis_q, mis_d;
  logic [3:0]  ff_q, ff_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        miss_s;

  assign miss_s = (f_in != EXP_MASK[abcd_q]);

  // Next-state and result update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    tt_d    = tt_q;
    mis_d   = mis_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          abcd_d  = 4'd0;
          tt_d    = 16'h0000;
          mis_d   = 5'd0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        tt_d[abcd_q] = f_in;
        if (miss_s) begin
          mis_d = mis_q + 5'd1;
          // Only the first mismatch of the sweep records its index.
          if (mis_q == 5'd0) begin
            ff_d = abcd_q;
          end else begin
            ff_d = ff_q;
          end
        end else begin
          mis_d = mis_q;
        end
        if (abcd_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          abcd_d  = abcd_q + 4'd1;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        pass_d  = (mis_q == 5'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      abcd_q  <= 4'd0;
      tt_q    <= 16'h0000;
      mis_q   <= 5'd0;
      ff_q    <= 4'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign abcd         = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;
  assign mismatch_cnt = mis_q;
  assign first_fail   = ff_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Directed bench for truth_table_sweep_ctrl: default instance plus a
// SETTLE_CYC=1 instance, both driven by a gate-level model of F.
module tb_truth_table_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  abcd;
  logic        f_in;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  logic        start1 = 1'b0;
  logic [3:0]  abcd1;
  logic        f_in1;
  logic        busy1, done1, pass1;
  logic [15:0] tt1;
  logic [4:0]  mismatch_cnt1;
  logic [3:0]  first_fail1;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;  // 0: correct function, 1: tied low, 2: inverted

  always #5 clk = ~clk;

  // F = D&(A|B|C) | ~A&B, zero at minterms 0,1,2,8,10,12,14.
  function automatic logic gate_f(input logic [3:0] v);
    return (v[0] & (v[3] | v[2] | v[1])) | (~v[3] & v[2]);
  endfunction

  assign f_in  = (mode == 0) ? gate_f(abcd) : (mode == 1) ? 1'b0 : ~gate_f(abcd);
  assign f_in1 = gate_f(abcd1);

  truth_table_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abcd(abcd), .f_in(f_in),
    .busy(busy), .done(done), .tt(tt), .mismatch_cnt(mismatch_cnt),
    .first_fail(first_fail), .pass(pass)
  );

  truth_table_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .f_in(f_in1),
    .busy(busy1), .done(done1), .tt(tt1), .mismatch_cnt(mismatch_cnt1),
    .first_fail(first_fail1), .pass(pass1)
  );

  // Pulse start for one edge and count cycles until done (bounded).
  task automatic run_sweep(output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [15:0] exp_tt, input logic [4:0] exp_mc,
                              input logic [3:0] exp_ff, input logic exp_pass);
    vectors++;
    if (lat !== 48) begin miscompares++; $display("FAIL %s_latency got %0d want 48", name, lat); end
    vectors++;
    if (tt !== exp_tt) begin miscompares++; $display("FAIL %s_tt got %h want %h", name, tt, exp_tt); end
    vectors++;
    if (mismatch_cnt !== exp_mc) begin miscompares++; $display("FAIL %s_cnt got %0d want %0d", name, mismatch_cnt, exp_mc); end
    vectors++;
    if (first_fail !== exp_ff) begin miscompares++; $display("FAIL %s_first got %0d want %0d", name, first_fail, exp_ff); end
    @(posedge clk); #1;
    vectors++;
    if (pass !== exp_pass || done !== 1'b0 || busy !== 1'b0 || abcd !== 4'd15) begin
      miscompares++;
      $display("FAIL %s_end got pass=%b done=%b busy=%b abcd=%0d want pass=%b done=0 busy=0 abcd=15",
               name, pass, done, busy, abcd, exp_pass);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || tt !== 16'h0 || mismatch_cnt !== 5'd0 ||
        first_fail !== 4'd0 || pass !== 1'b0 || abcd !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b tt=%h cnt=%0d ff=%0d pass=%b abcd=%0d want all zero",
               busy, done, tt, mismatch_cnt, first_fail, pass, abcd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_gate();
    int lat;
    mode = 0;
    run_sweep(lat);
    check_result("gate", lat, 16'hAAF8, 5'd0, 4'd0, 1'b1);
  endtask

  task automatic test_zero();
    int lat;
    mode = 1;
    run_sweep(lat);
    check_result("zero", lat, 16'h0000, 5'd9, 4'd3, 1'b0);
  endtask

  task automatic test_inverted();
    int lat;
    mode = 2;
    run_sweep(lat);
    check_result("inv", lat, 16'h5507, 5'd16, 4'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones;
    mode = 0;
    dones = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (lat < 47) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1) dones++;
      if (lat == 10) start = 1'b1;
      if (lat == 11) start = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || dones !== 0) begin
      miscompares++; $display("FAIL b2b_single_done got done=%b early=%0d want done=1 early=0", done, dones);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      miscompares++; $display("FAIL b2b_idle got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
    end
    @(posedge clk); #1; start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pass !== 1'b0 || abcd !== 4'd0) begin
      miscompares++; $display("FAIL b2b_restart got busy=%b pass=%b abcd=%0d want 1 0 0", busy, pass, abcd);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_result("b2b_second", lat, 16'hAAF8, 5'd0, 4'd0, 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    int lat;
    int dones;
    mode = 2;
    dones = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || tt !== 16'h0 || mismatch_cnt !== 5'd0 ||
        first_fail !== 4'd0 || pass !== 1'b0 || abcd !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b done=%b tt=%h cnt=%0d ff=%0d pass=%b abcd=%0d want all zero",
               busy, done, tt, mismatch_cnt, first_fail, pass, abcd);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_abort got dones=%0d busy=%b want 0 0", dones, busy);
    end
    mode = 0;
    run_sweep(lat);
    check_result("after_reset", lat, 16'hAAF8, 5'd0, 4'd0, 1'b1);
  endtask

  task automatic test_settle1();
    int lat;
    int bad_hold;
    bad_hold = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      if (lat < 32 && abcd1 !== 4'(lat / 2)) bad_hold++;
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== 32) begin miscompares++; $display("FAIL s1_latency got %0d want 32", lat); end
    vectors++;
    if (bad_hold !== 0) begin miscompares++; $display("FAIL s1_hold got %0d bad cycles want 0", bad_hold); end
    vectors++;
    if (tt1 !== 16'hAAF8 || mismatch_cnt1 !== 5'd0 || first_fail1 !== 4'd0) begin
      miscompares++;
      $display("FAIL s1_result got tt=%h cnt=%0d ff=%0d want aaf8 0 0", tt1, mismatch_cnt1, first_fail1);
    end
    @(posedge clk); #1;
    vectors++;
    if (pass1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++; $display("FAIL s1_pass got pass=%b busy=%b want 1 0", pass1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_gate();
    test_zero();
    test_inverted();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep_ctrl.md
TRUTH_TABLE_SWEEP_CTRL -- requirements
Module: truth_table_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, wait cycles after each ABCD change before sampling; legal range 1..15.
REQ-002 SHALL have parameter EXP_MASK, default 16'hAAF8, expected F per index (bit i = F at ABCD=i), i.e. F = PI M(0,1,2,8,10,12,14).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one sweep, sampled in IDLE only.
REQ-006 SHALL have port abcd  output  4  drive to function under test, abcd[3]=A ... abcd[0]=D.
REQ-007 SHALL have port f_in  input  1  output F of function under test.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL have port tt  output  16  captured truth table, bit i = f_in sampled at abcd=i.
REQ-011 SHALL have port mismatch_cnt  output  5  count of indices where tt differs from EXP_MASK, 0..16.
REQ-012 SHALL have port first_fail  output  4  lowest mismatching index, 0 if none.
REQ-013 SHALL have port pass  output  1  high when the last completed sweep had mismatch_cnt = 0.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL, at the edge: set abcd=0, clear tt, mismatch_cnt, first_fail and pass, load settle counter with SETTLE_CYC-1, and enter SETTLE.
REQ-016 SETTLE SHALL decrement the counter each cycle and enter SAMPLE on the edge where the counter is 0, so it lasts exactly SETTLE_CYC cycles.
REQ-017 SAMPLE SHALL, at its edge, write f_in into tt[abcd].
REQ-018 SAMPLE SHALL, if f_in != EXP_MASK[abcd], increment mismatch_cnt and load first_fail=abcd when this is the first mismatch of the sweep.
REQ-019 SAMPLE SHALL, if abcd=15, enter DONE; otherwise it SHALL increment abcd, reload the counter and return to SETTLE.
REQ-020 abcd SHALL NOT wrap from 15 to 0 during a sweep; it SHALL hold 15 through DONE and IDLE until the next start.
REQ-021 DONE SHALL last one cycle with done=1.
REQ-022 DONE SHALL set pass=1 if mismatch_cnt = 0 (including the final sample's update), then enter IDLE.
REQ-023 done SHALL rise exactly 16*(SETTLE_CYC+1) cycles after the edge that accepted start (48 for the default).
REQ-024 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored outside IDLE; a start held high through DONE SHALL launch a new sweep on the first IDLE cycle.
REQ-026 tt, mismatch_cnt, first_fail and pass SHALL hold their values from the end of a sweep until the next accepted start.
REQ-027 mismatch_cnt SHALL be 5 bits and SHALL NOT saturate or wrap; 16 is its maximum value.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, abcd=0, tt=0, mismatch_cnt=0, first_fail=0, pass=0, busy=0, done=0 and settle counter=0, regardless of clk.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no done pulse, and SHALL discard all partial results.
REQ-030 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-031 Correct gate-level function on f_in, default params, start pulse -> done at +48 cycles, tt=16'hAAF8, mismatch_cnt=0, first_fail=0, pass=1.
REQ-032 f_in tied 0 -> tt=16'h0000, mismatch_cnt=9, first_fail=3, pass=0.
REQ-033 f_in = inverted function -> tt=16'h5507, mismatch_cnt=16, first_fail=0, pass=0.
REQ-034 Second start pulse at cycle 10 of a sweep -> ignored; exactly one done pulse at +48; a start held high through DONE -> new sweep, busy=1 on the next cycle.
REQ-035 rst_n low at cycle 20 of a sweep -> all outputs 0 asynchronously with no done pulse; a restart after reset -> normal result per REQ-031.
REQ-036 SETTLE_CYC=1 -> done at +32 cycles; each abcd value is held for exactly 2 cycles; results identical to REQ-031.
